// File: rtl/rf_wb_arbiter.sv
// Write-back arbiter for the 2R1W register file: shares the single write port between
// the ALU, the long-latency unit and debug, stages the granted write and forwards it.
module rf_wb_arbiter #(
   parameter int XLEN         = 32,
   parameter int AW           = 5,
   parameter int STARVE_LIMIT = 4
) (
   input  logic            clk,
   input  logic            reset_n,
   input  logic            a_valid,
   output logic            a_ready,
   input  logic [AW-1:0]   a_addr,
   input  logic [XLEN-1:0] a_data,
   input  logic            b_valid,
   output logic            b_ready,
   input  logic [AW-1:0]   b_addr,
   input  logic [XLEN-1:0] b_data,
   input  logic            d_valid,
   output logic            d_ready,
   input  logic [AW-1:0]   d_addr,
   input  logic [XLEN-1:0] d_data,
   input  logic [AW-1:0]   ra1,
   input  logic [AW-1:0]   ra2,
   output logic [XLEN-1:0] rd1,
   output logic [XLEN-1:0] rd2,
   output logic [AW-1:0]   io_rf_ra1,
   output logic [AW-1:0]   io_rf_ra2,
   input  logic [XLEN-1:0] io_rf_rd1,
   input  logic [XLEN-1:0] io_rf_rd2,
   output logic [AW-1:0]   io_rf_wa,
   output logic            io_rf_wen,
   output logic [XLEN-1:0] io_rf_wd
);

   localparam logic [3:0]    STARVE_MAX = 4'(STARVE_LIMIT);
   localparam logic [AW-1:0] X0_ADDR    = {AW{1'b0}};

   logic            boost_s;
   logic            a_hs_s;
   logic            b_hs_s;
   logic            d_hs_s;
   logic            fwd1_s;
   logic            fwd2_s;
   logic [3:0]      starve_cnt_q, starve_cnt_d;
   logic            wen_q, wen_d;
   logic [AW-1:0]   wa_q, wa_d;
   logic [XLEN-1:0] wd_q, wd_d;

   // Grants: fixed priority A > B > D, with B promoted once it has waited STARVE_LIMIT cycles.
   always_comb begin
      boost_s = (starve_cnt_q == STARVE_MAX) && b_valid;
      if (reset_n) begin
         a_ready = !boost_s;
         b_ready = boost_s || !a_valid;
         d_ready = !a_valid && !b_valid;
      end else begin
         a_ready = 1'b0;
         b_ready = 1'b0;
         d_ready = 1'b0;
      end
      a_hs_s = a_valid && a_ready;
      b_hs_s = b_valid && b_ready;
      d_hs_s = d_valid && d_ready;
   end

   // Next write-stage contents and starvation count; x0 writes are accepted but not enabled.
   always_comb begin
      wen_d = 1'b0;
      wa_d  = wa_q;
      wd_d  = wd_q;
      if (a_hs_s) begin
         wen_d = (a_addr != X0_ADDR);
         wa_d  = a_addr;
         wd_d  = a_data;
      end else if (b_hs_s) begin
         wen_d = (b_addr != X0_ADDR);
         wa_d  = b_addr;
         wd_d  = b_data;
      end else if (d_hs_s) begin
         wen_d = (d_addr != X0_ADDR);
         wa_d  = d_addr;
         wd_d  = d_data;
      end else begin
         wen_d = 1'b0;
      end

      if (b_valid && !b_ready) begin
         if (starve_cnt_q >= STARVE_MAX) begin
            starve_cnt_d = STARVE_MAX;
         end else begin
            starve_cnt_d = starve_cnt_q + 4'd1;
         end
      end else begin
         starve_cnt_d = 4'd0;
      end
   end

   // State registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         starve_cnt_q <= 4'd0;
         wen_q        <= 1'b0;
         wa_q         <= X0_ADDR;
         wd_q         <= {XLEN{1'b0}};
      end else begin
         starve_cnt_q <= starve_cnt_d;
         wen_q        <= wen_d;
         wa_q         <= wa_d;
         wd_q         <= wd_d;
      end
   end

   // Write port and forwarding; reset masks the staged enable so a pending write never lands.
   always_comb begin
      io_rf_wen = wen_q && reset_n;
      io_rf_wa  = wa_q;
      io_rf_wd  = wd_q;
      io_rf_ra1 = ra1;
      io_rf_ra2 = ra2;
      fwd1_s    = io_rf_wen && (wa_q == ra1) && (ra1 != X0_ADDR);
      fwd2_s    = io_rf_wen && (wa_q == ra2) && (ra2 != X0_ADDR);
      if (fwd1_s) begin
         rd1 = wd_q;
      end else begin
         rd1 = io_rf_rd1;
      end
      if (fwd2_s) begin
         rd2 = wd_q;
      end else begin
         rd2 = io_rf_rd2;
      end
   end

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Randomized bench for rf_wb_arbiter: a behavioural arbiter/register-file model checked
// every cycle, plus directed sequences with hand-computed expectations.
module tb_rf_wb_arbiter;

   localparam int XLEN  = 32;
   localparam int AW    = 5;
   localparam int LIMIT = 4;

   logic            clk = 1'b0;
   logic            reset_n;
   logic            a_valid, b_valid, d_valid;
   logic            a_ready, b_ready, d_ready;
   logic [AW-1:0]   a_addr, b_addr, d_addr, ra1, ra2;
   logic [XLEN-1:0] a_data, b_data, d_data;
   logic [XLEN-1:0] rd1, rd2, io_rf_rd1, io_rf_rd2, io_rf_wd;
   logic [AW-1:0]   io_rf_ra1, io_rf_ra2, io_rf_wa;
   logic            io_rf_wen;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   rf_wb_arbiter #(.XLEN(XLEN), .AW(AW), .STARVE_LIMIT(LIMIT)) dut (
      .clk(clk), .reset_n(reset_n),
      .a_valid(a_valid), .a_ready(a_ready), .a_addr(a_addr), .a_data(a_data),
      .b_valid(b_valid), .b_ready(b_ready), .b_addr(b_addr), .b_data(b_data),
      .d_valid(d_valid), .d_ready(d_ready), .d_addr(d_addr), .d_data(d_data),
      .ra1(ra1), .ra2(ra2), .rd1(rd1), .rd2(rd2),
      .io_rf_ra1(io_rf_ra1), .io_rf_ra2(io_rf_ra2),
      .io_rf_rd1(io_rf_rd1), .io_rf_rd2(io_rf_rd2),
      .io_rf_wa(io_rf_wa), .io_rf_wen(io_rf_wen), .io_rf_wd(io_rf_wd)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h, expected %h at t=%0t", name, act, exp, $time);
      end
   endtask

   // Register file seen by the DUT: x0 reads zero, writes land at the rising edge.
   logic [XLEN-1:0] rf_mem [32];
   assign io_rf_rd1 = (io_rf_ra1 == 5'd0) ? 32'd0 : rf_mem[io_rf_ra1];
   assign io_rf_rd2 = (io_rf_ra2 == 5'd0) ? 32'd0 : rf_mem[io_rf_ra2];

   initial begin
      for (int i = 0; i < 32; i++) rf_mem[i] = (i == 0) ? 32'd0 : (32'h1000_0000 | 32'(i));
      forever begin
         @(posedge clk);
         if (io_rf_wen && io_rf_wa != 5'd0) rf_mem[io_rf_wa] <= io_rf_wd;
      end
   end

   // Reference model: pending write, how long B has been refused, and expected memory.
   logic            m_valid  = 1'b0;
   logic            m_wen    = 1'b0;
   logic [AW-1:0]   m_wa     = 5'd0;
   logic [XLEN-1:0] m_wd     = 32'd0;
   int              m_waited = 0;
   logic [XLEN-1:0] ref_mem [32];

   function automatic logic [2:0] exp_readies();
      logic boost;
      boost = (m_waited == LIMIT) && b_valid;
      if (!reset_n) return 3'b000;
      return {!boost, boost || !a_valid, !a_valid && !b_valid};
   endfunction

   initial begin
      logic [2:0] r;
      for (int i = 0; i < 32; i++) ref_mem[i] = (i == 0) ? 32'd0 : (32'h1000_0000 | 32'(i));
      forever begin
         @(posedge clk);
         if (!reset_n) begin
            m_valid  = 1'b1;
            m_wen    = 1'b0;
            m_wa     = 5'd0;
            m_wd     = 32'd0;
            m_waited = 0;
         end else begin
            if (m_wen && m_wa != 5'd0) ref_mem[m_wa] = m_wd;
            r = exp_readies();
            if (a_valid && r[2]) begin
               m_wen = (a_addr != 5'd0); m_wa = a_addr; m_wd = a_data;
            end else if (b_valid && r[1]) begin
               m_wen = (b_addr != 5'd0); m_wa = b_addr; m_wd = b_data;
            end else if (d_valid && r[0]) begin
               m_wen = (d_addr != 5'd0); m_wa = d_addr; m_wd = d_data;
            end else begin
               m_wen = 1'b0;
            end
            if (b_valid && !r[1]) begin
               if (m_waited < LIMIT) m_waited++;
            end else begin
               m_waited = 0;
            end
         end
      end
   end

   // Per-cycle comparison of every output against the model.
   initial begin
      logic [2:0]      r;
      logic            ewen;
      logic [XLEN-1:0] e1, e2;
      int              nhs;
      forever begin
         @(negedge clk);
         if (m_valid) begin
            r    = exp_readies();
            ewen = m_wen && reset_n;
            e1   = (ewen && m_wa == ra1 && ra1 != 5'd0) ? m_wd : ref_mem[ra1];
            e2   = (ewen && m_wa == ra2 && ra2 != 5'd0) ? m_wd : ref_mem[ra2];
            nhs  = int'(a_valid && a_ready) + int'(b_valid && b_ready) + int'(d_valid && d_ready);
            check("a_ready", 32'(a_ready), 32'(r[2]));
            check("b_ready", 32'(b_ready), 32'(r[1]));
            check("d_ready", 32'(d_ready), 32'(r[0]));
            check("io_rf_wen", 32'(io_rf_wen), 32'(ewen));
            check("io_rf_wa", 32'(io_rf_wa), 32'(m_wa));
            check("io_rf_wd", io_rf_wd, m_wd);
            check("io_rf_ra1", 32'(io_rf_ra1), 32'(ra1));
            check("io_rf_ra2", 32'(io_rf_ra2), 32'(ra2));
            check("rd1", rd1, e1);
            check("rd2", rd2, e2);
            check("single_handshake", 32'(nhs > 1), 32'd0);
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not end, got t=%0t expected < 500000", $time);
      $fatal(1);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic a_hs, b_hs, d_hs;
      reset_n = 1'b0;
      a_valid = 1'b1; a_addr = 5'd1; a_data = 32'h1111_1111;
      b_valid = 1'b1; b_addr = 5'd2; b_data = 32'h2222_2222;
      d_valid = 1'b1; d_addr = 5'd3; d_data = 32'h3333_3333;
      ra1 = 5'd0; ra2 = 5'd0;

      // Reset held three cycles with every requester valid.
      repeat (3) begin
         @(negedge clk);
         check("rst_a_ready", 32'(a_ready), 32'd0);
         check("rst_b_ready", 32'(b_ready), 32'd0);
         check("rst_d_ready", 32'(d_ready), 32'd0);
         check("rst_wen", 32'(io_rf_wen), 32'd0);
         check("rst_wa", 32'(io_rf_wa), 32'd0);
         check("rst_wd", io_rf_wd, 32'd0);
      end
      tick();
      reset_n = 1'b1; a_valid = 1'b0; b_valid = 1'b0; d_valid = 1'b0;

      // Single write of x5 with forwarding, then RegFile read-back.
      tick();
      a_valid = 1'b1; a_addr = 5'd5; a_data = 32'hDEAD_BEEF; ra1 = 5'd5;
      @(negedge clk);
      check("sw_a_ready", 32'(a_ready), 32'd1);
      tick();
      a_valid = 1'b0;
      @(negedge clk);
      check("sw_wen", 32'(io_rf_wen), 32'd1);
      check("sw_wa", 32'(io_rf_wa), 32'd5);
      check("sw_rd1_fwd", rd1, 32'hDEAD_BEEF);
      check("sw_rf_rd1_old", io_rf_rd1, 32'h1000_0005);
      tick();
      @(negedge clk);
      check("sw_rd1_rf", rd1, 32'hDEAD_BEEF);
      check("sw_rf_rd1_new", io_rf_rd1, 32'hDEAD_BEEF);

      // Priority A > B > D: writes land in order x1, x2, x3.
      tick();
      a_valid = 1'b1; a_addr = 5'd1; a_data = 32'd11;
      b_valid = 1'b1; b_addr = 5'd2; b_data = 32'd22;
      d_valid = 1'b1; d_addr = 5'd3; d_data = 32'd33;
      @(negedge clk);
      check("pri_a_ready", 32'(a_ready), 32'd1);
      check("pri_b_ready", 32'(b_ready), 32'd0);
      check("pri_d_ready", 32'(d_ready), 32'd0);
      tick();
      a_valid = 1'b0;
      @(negedge clk);
      check("pri_b_ready2", 32'(b_ready), 32'd1);
      check("pri_wa_1", 32'(io_rf_wa), 32'd1);
      tick();
      b_valid = 1'b0;
      @(negedge clk);
      check("pri_d_ready3", 32'(d_ready), 32'd1);
      check("pri_wa_2", 32'(io_rf_wa), 32'd2);
      tick();
      d_valid = 1'b0;
      @(negedge clk);
      check("pri_wa_3", 32'(io_rf_wa), 32'd3);
      check("pri_wd_3", io_rf_wd, 32'd33);

      // Starvation: A streams, B (x7) must be granted in cycle 4 with A stalled there only.
      tick();
      a_valid = 1'b1; a_addr = 5'd10; a_data = 32'd100;
      b_valid = 1'b1; b_addr = 5'd7;  b_data = 32'h0000_1234;
      for (int k = 0; k < 7; k++) begin
         @(negedge clk);
         check("starve_b_ready", 32'(b_ready), 32'(k == 4));
         check("starve_a_ready", 32'(a_ready), 32'(k != 4));
         if (k == 5) begin
            check("starve_wa_b", 32'(io_rf_wa), 32'd7);
            check("starve_wd_b", io_rf_wd, 32'h0000_1234);
         end
         a_hs = a_valid && a_ready;
         b_hs = b_valid && b_ready;
         tick();
         if (a_hs) a_data = a_data + 32'd1;
         if (b_hs) b_valid = 1'b0;
      end

      // x0 write: accepted, not enabled, no forwarding on ra2 = 0.
      a_valid = 1'b1; a_addr = 5'd0; a_data = 32'hFFFF_FFFF; ra2 = 5'd0;
      @(negedge clk);
      check("x0_a_ready", 32'(a_ready), 32'd1);
      tick();
      a_valid = 1'b0;
      @(negedge clk);
      check("x0_wen", 32'(io_rf_wen), 32'd0);
      check("x0_wd", io_rf_wd, 32'hFFFF_FFFF);
      check("x0_rd2", rd2, 32'd0);

      // Reset arriving while a debug write to x9 is staged: the write is dropped.
      tick();
      d_valid = 1'b1; d_addr = 5'd9; d_data = 32'hA5A5_A5A5;
      @(negedge clk);
      check("rmo_d_ready", 32'(d_ready), 32'd1);
      tick();
      reset_n = 1'b0; d_valid = 1'b0;
      @(negedge clk);
      check("rmo_wen", 32'(io_rf_wen), 32'd0);
      tick();
      reset_n = 1'b1;
      @(negedge clk);
      check("rmo_wen2", 32'(io_rf_wen), 32'd0);
      check("rmo_x9_kept", rf_mem[9], 32'h1000_0009);

      // Randomized traffic with held requests and occasional reset pulses.
      for (int c = 0; c < 800; c++) begin
         @(negedge clk);
         a_hs = a_valid && a_ready;
         b_hs = b_valid && b_ready;
         d_hs = d_valid && d_ready;
         tick();
         reset_n = ($urandom_range(0, 99) != 0);
         if (!a_valid || a_hs) begin
            a_valid = ($urandom_range(0, 99) < 70);
            a_addr  = 5'($urandom_range(0, 7));
            a_data  = $urandom;
         end
         if (!b_valid || b_hs) begin
            b_valid = ($urandom_range(0, 99) < 50);
            b_addr  = 5'($urandom_range(0, 31));
            b_data  = $urandom;
         end
         if (!d_valid || d_hs) begin
            d_valid = ($urandom_range(0, 99) < 40);
            d_addr  = 5'($urandom_range(0, 7));
            d_data  = $urandom;
         end
         ra1 = 5'($urandom_range(0, 7));
         ra2 = 5'($urandom_range(0, 7));
      end

      // Drain and compare the whole register file against the model.
      a_valid = 1'b0; b_valid = 1'b0; d_valid = 1'b0; reset_n = 1'b1;
      repeat (3) tick();
      @(negedge clk);
      for (int i = 0; i < 32; i++) check("rf_final", rf_mem[i], ref_mem[i]);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/rf_wb_arbiter.md
# rf_wb_arbiter

Write-back arbiter and read-forwarding controller for the 32x32 2R1W integer register file (`RegFile`). It shares the single write port between three requesters: the ALU write-back, the long-latency unit write-back (load/mul) and the debug port. Every granted write is registered for one cycle before it drives the RegFile write port. While a write sits in that stage, matching reads are forwarded so the pipeline never sees stale data.

## Interface

Parameters:
- `XLEN`, 32, data width.
- `AW`, 5, register address width.
- `STARVE_LIMIT`, 4, maximum consecutive cycles B may be refused while valid; range 1..15.

Ports:
- `clk`  in  1  clock; all state updates on rising edge.
- `reset_n`  in  1  synchronous, active-low reset.
- `a_valid` / `a_ready`  in / out  1  ALU write-back handshake.
- `a_addr`, `a_data`  in  AW, XLEN  ALU destination register and value.
- `b_valid` / `b_ready`  in / out  1  long-latency unit write-back handshake.
- `b_addr`, `b_data`  in  AW, XLEN  long-latency unit destination register and value.
- `d_valid` / `d_ready`  in / out  1  debug write handshake.
- `d_addr`, `d_data`  in  AW, XLEN  debug destination register and value.
- `ra1`, `ra2`  in  AW  pipeline read addresses.
- `rd1`, `rd2`  out  XLEN  forwarded read data to the pipeline.
- `io_rf_ra1`, `io_rf_ra2`  out  AW  to RegFile; equal to `ra1`/`ra2` (combinational pass-through).
- `io_rf_rd1`, `io_rf_rd2`  in  XLEN  from RegFile.
- `io_rf_wa`  out  AW  RegFile write address (registered).
- `io_rf_wen`  out  1  RegFile write enable (registered).
- `io_rf_wd`  out  XLEN  RegFile write data (registered).

## Operation

**Handshake rules**
- Handshake is valid && ready, sampled at the rising edge.
- A requester holds valid, addr and data stable until its handshake completes.
- Readies are combinational from the valids and the boost state. Readies never depend on the write stage.

**Arbitration**
- Fixed priority A > B > D, with an anti-starvation boost for B.
- `boost` = (`starve_cnt` == `STARVE_LIMIT`) && `b_valid`.
- Grant equations:
  - `a_ready` = !`boost`.
  - `b_ready` = `boost` || !`a_valid`.
  - `d_ready` = !`a_valid` && !`b_valid`.
- At most one handshake occurs per cycle. Any two-handshake case is a bug; the bench asserts on it.

**Starvation counter** (`starve_cnt`, 4 bits)
- Increments when `b_valid` && !`b_ready`.
- Clears on a B handshake or when `b_valid` is low.
- Saturates at `STARVE_LIMIT`.

**Write stage**
- On a handshake, the next cycle drives `io_rf_wa`/`io_rf_wd` = the granted addr/data.
- `io_rf_wen` = 1 only if the granted addr is nonzero. Writes to x0 are accepted (ready asserted) and then dropped.
- With no handshake, `io_rf_wen` = 0 next cycle; `io_rf_wa`/`io_rf_wd` hold their previous values.

**Forwarding**
- `rd1` = `io_rf_wd` if `io_rf_wen` && `io_rf_wa` == `ra1` && `ra1` != 0; otherwise `rd1` = `io_rf_rd1`. `rd2` uses the same rule with `ra2`/`io_rf_rd2`.
- D has no anti-starvation guarantee; debug waits for an idle cycle.

## Timing

- **Reset:** while `reset_n` is low, `a_ready`/`b_ready`/`d_ready` are forced to 0.
- **Reset values** (at the first edge with `reset_n` low): `io_rf_wen` = 0, `io_rf_wa` = 0, `io_rf_wd` = 0, `starve_cnt` = 0. `rd1`/`rd2` follow `io_rf_rd1`/`io_rf_rd2`.
- **Reset mid-operation:** a write sitting in the write stage when reset asserts is discarded, never written. A held request is serviced normally after `reset_n` rises.
- **Write latency:** handshake in cycle N, `io_rf_wen` in cycle N+1, RegFile updated at the end of N+1, value visible from RegFile in N+2. Forwarding covers N+1.
- **Throughput:** one write per cycle, sustained back-to-back with no bubbles.
- **B wait bound:** with A continuously valid, B waits exactly `STARVE_LIMIT` cycles. It is granted on cycle `STARVE_LIMIT` (0-based from first valid); A is stalled in that cycle only.
- **Back-to-back B:** after a B grant the counter restarts from 0. If `b_valid` stays high for a new request, the next boost arrives `STARVE_LIMIT` cycles later.

## Test plan

- **Reset:** hold `reset_n` = 0 for 3 cycles with all valids high -> all readies 0; `io_rf_wen`/`io_rf_wa`/`io_rf_wd` = 0.
- **Single write:** A writes x5 = 0xDEADBEEF in cycle N; `ra1` = 5 in N+1 -> `io_rf_wen` = 1, `io_rf_wa` = 5, `rd1` = 0xDEADBEEF (forwarded) while `io_rf_rd1` is still old. In N+2, `rd1` = 0xDEADBEEF from RegFile.
- **Priority:** A, B, D all valid in one cycle (A→x1, B→x2, D→x3) -> only `a_ready` high; write order over following cycles is x1, x2, x3.
- **Starvation:** A valid continuously with new data each cycle, B valid for x7 = 0x1234, `STARVE_LIMIT` = 4 -> `b_ready` first high in cycle 4 with `a_ready` = 0 that cycle; A resumes in cycle 5.
- **x0 write:** A writes x0 = 0xFFFFFFFF with `ra2` = 0 -> `a_ready` = 1, `io_rf_wen` = 0 next cycle, `rd2` = `io_rf_rd2` (no forwarding).
- **Reset mid-operation:** D handshake for x9 = 0xA5A5A5A5 in cycle N, `reset_n` = 0 at the edge ending N -> `io_rf_wen` = 0 in N+1; no RegFile write to x9 occurs.
